key_conditioner: RTL
====================

// Module: key_conditioner
// PURPOSE
//  Upstream input stage for top_level_module. Conditions one raw push-button (e.g. modeControl):
//  2-flop synchronizer, debounce FSM, and single-cycle press/release/long-press pulses.
//  The display/mode logic consumes these pulses instead of the raw pin.
// PARAMETERS
//  DEBOUNCE_CNT  1000000    stable cycles required to accept a level change (20 ms at 50 MHz); >=1
//  LONG_CNT      100000000  cycles after press_pulse until long_pulse (2 s at 50 MHz); >=1
//  REPEAT_CNT    10000000   auto-repeat period in cycles (used only with KEY_AUTO_REPEAT_EN)
//  CNT_W         27         counter width; 2**CNT_W > max(DEBOUNCE_CNT, LONG_CNT, REPEAT_CNT)
//  ACTIVE_LOW    1          1: key_in=0 means pressed; 0: key_in=1 means pressed
// PORTS
//  sysclk         in   1  system clock, rising edge
//  resetb         in   1  asynchronous active-low reset
//  key_in         in   1  raw asynchronous button level
//  key_level      out  1  debounced level, 1 = pressed
//  press_pulse    out  1  1-cycle pulse on accepted press (and on auto-repeat)
//  release_pulse  out  1  1-cycle pulse on accepted release
//  long_pulse     out  1  1-cycle pulse once per press after LONG_CNT cycles held
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, counters 0, sync flops hold "not pressed".
//  - key_p = key_in ^ ACTIVE_LOW; two-flop sync -> key_s. All outputs registered.
//  - FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; cnt = debounce counter:
//    IDLE: key_s=1 -> PRESS_WAIT, cnt<=0.
//    PRESS_WAIT: key_s=0 -> IDLE (bounce, no output); else cnt==DEBOUNCE_CNT-1 -> HELD,
//      press_pulse<=1, key_level<=1, hold_cnt<=0; else cnt<=cnt+1.
//    HELD: key_s=0 -> RELEASE_WAIT, cnt<=0.
//    RELEASE_WAIT: key_s=1 -> HELD (glitch; no pulse, hold_cnt keeps running);
//      else cnt==DEBOUNCE_CNT-1 -> IDLE, release_pulse<=1, key_level<=0; else cnt<=cnt+1.
//  - Latency: first edge k sampling pressed key_in, stable -> press_pulse high for the cycle after
//    edge k+DEBOUNCE_CNT+2. Release latency identical.
//  - hold_cnt increments in HELD and RELEASE_WAIT, saturates at LONG_CNT; long_pulse<=1 on the edge
//    it becomes LONG_CNT (LONG_CNT edges after press_pulse edge). Exactly once per press.
//  - Simultaneous long_pulse and release_pulse on the same edge: both asserted.
//  - A glitch shorter than DEBOUNCE_CNT in either wait state never changes key_level.
//  - Reset mid-operation: outputs drop to 0 immediately (async); key held through reset release
//    is treated as a new press (full debounce, then press_pulse).
//  - press_pulse, release_pulse never asserted on the same edge.
// CONFIGURATION
//  KEY_AUTO_REPEAT_EN defined: after long_pulse, while in HELD, press_pulse re-fires every
//    REPEAT_CNT cycles (rpt_cnt cleared on long_pulse, frozen in RELEASE_WAIT, cleared in IDLE).
//    First repeat REPEAT_CNT edges after long_pulse edge.
//  Not defined: exactly one press_pulse per press; REPEAT_CNT ignored; no rpt_cnt logic.
// TESTING  (DEBOUNCE_CNT=4, LONG_CNT=20, REPEAT_CNT=8, ACTIVE_LOW=1)
//  1 key_in 1->0 first sampled at edge k, held -> press_pulse=1 only after edge k+6; key_level=1 from k+6.
//  2 key_in low 3 cycles then high -> no press_pulse, key_level stays 0, FSM back to IDLE.
//  3 pressed, key_in high from edge m -> release_pulse after edge m+6, key_level=0; a 2-cycle low
//    glitch inside that window -> no release_pulse, key_level stays 1.
//  4 hold 40 cycles -> long_pulse once, 20 edges after press_pulse edge; no press_pulse repeats
//    (macro off); with KEY_AUTO_REPEAT_EN press_pulse at long+8, long+16.
//  5 resetb=0 while HELD -> all outputs 0 immediately; resetb=1 with key still low -> press_pulse
//    after debounce, long_pulse counted fresh.
//  6 ACTIVE_LOW=0: key_in=1 held -> press_pulse with same 6-edge latency; key_in=0 ignored in IDLE.

Source files
------------

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : key_conditioner
// Description : Input conditioning for one raw push-button. It synchronises
//               the pin into sysclk with two flops and debounces it with a
//               4-state FSM. It then produces registered single-cycle pulses
//               for press, release and long-press.
//
//               Optional feature macro: KEY_AUTO_REPEAT_EN
//                 defined   -> after long_pulse, press_pulse re-fires every
//                              REPEAT_CNT cycles while the key stays HELD
//                 undefined -> exactly one press_pulse per press
//
// Ports       : sysclk        in  system clock, rising edge
//               resetb        in  asynchronous active-low reset
//               key_in        in  raw asynchronous button level
//               key_level     out debounced level, 1 = pressed
//               press_pulse   out 1-cycle pulse on accepted press / repeat
//               release_pulse out 1-cycle pulse on accepted release
//               long_pulse    out 1-cycle pulse once per press after
//                                 LONG_CNT cycles held
// Revision    : 1.0  initial release
// ============================================================================
module key_conditioner #(
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int LONG_CNT     = 100000000,
    parameter int REPEAT_CNT   = 10000000,
    parameter int CNT_W        = 27,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic sysclk,
    input  logic resetb,
    input  logic key_in,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    // ------------------------------------------------------------------
    // Elaboration-time sanity check: counters must hold every terminal
    // count.
    // ------------------------------------------------------------------
    localparam longint c_cnt_span = longint'(1) << CNT_W;

    if ((DEBOUNCE_CNT < 1) || (LONG_CNT < 1) ||
        (c_cnt_span <= longint'(DEBOUNCE_CNT)) ||
        (c_cnt_span <= longint'(LONG_CNT)) ||
        (c_cnt_span <= longint'(REPEAT_CNT))) begin : g_param_check
        $error("key_conditioner: illegal DEBOUNCE_CNT/LONG_CNT/REPEAT_CNT/CNT_W");
    end

    // ------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] c_zero     = '0;
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] c_long     = CNT_W'(LONG_CNT);
    localparam logic [CNT_W-1:0] c_long_m1  = CNT_W'(LONG_CNT - 1);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] c_rpt_last = CNT_W'(REPEAT_CNT - 1);
`endif

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    logic             r_sync1;
    logic             r_sync2;      // synchronised key, 1 = pressed
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;        // debounce counter
    logic [CNT_W-1:0] r_hold_cnt;   // cycles since accepted press

    logic             w_key_p;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_long_nxt;

`ifdef KEY_AUTO_REPEAT_EN
    logic [CNT_W-1:0] r_rpt_cnt;
    logic [CNT_W-1:0] w_rpt_nxt;
`endif

    // Normalise polarity before synchronising, so the flops reset to
    // "not pressed" regardless of ACTIVE_LOW.
    assign w_key_p = key_in ^ ACTIVE_LOW;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hold_nxt    = r_hold_cnt;
        w_level_nxt   = key_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        w_rpt_nxt     = r_rpt_cnt;
`endif

        // The hold counter keeps running through a release glitch, so a
        // bounce near the long-press threshold does not restart it.
        // It saturates at LONG_CNT, which makes long_pulse one-shot.
        if ((r_state == S_HELD) || (r_state == S_RELEASE_WAIT)) begin
            if (r_hold_cnt != c_long) begin
                w_hold_nxt = r_hold_cnt + c_one;
                if (r_hold_cnt == c_long_m1) begin
                    w_long_nxt = 1'b1;
                end
            end
        end

        case (r_state)
            S_IDLE: begin
                w_hold_nxt = c_zero;
`ifdef KEY_AUTO_REPEAT_EN
                w_rpt_nxt  = c_zero;
`endif
                if (r_sync2) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = c_zero;
                end
            end

            S_PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = S_HELD;
                    w_press_nxt = 1'b1;
                    w_level_nxt = 1'b1;
                    w_hold_nxt  = c_zero;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end

            S_HELD: begin
                if (!r_sync2) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = c_zero;
                end
`ifdef KEY_AUTO_REPEAT_EN
                // Repeat phase starts only once the hold counter has
                // saturated, i.e. after long_pulse has fired.
                if (r_hold_cnt == c_long) begin
                    if (r_rpt_cnt == c_rpt_last) begin
                        w_press_nxt = 1'b1;
                        w_rpt_nxt   = c_zero;
                    end else begin
                        w_rpt_nxt = r_rpt_cnt + c_one;
                    end
                end
`endif
            end

            S_RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = S_HELD;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt   = S_IDLE;
                    w_release_nxt = 1'b1;
                    w_level_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

`ifdef KEY_AUTO_REPEAT_EN
        // Repeat period is measured from the long_pulse edge.
        if (w_long_nxt) begin
            w_rpt_nxt = c_zero;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_state       <= S_IDLE;
            r_cnt         <= c_zero;
            r_hold_cnt    <= c_zero;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            r_sync1       <= w_key_p;
            r_sync2       <= r_sync1;
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_hold_cnt    <= w_hold_nxt;
            key_level     <= w_level_nxt;
            press_pulse   <= w_press_nxt;
            release_pulse <= w_release_nxt;
            long_pulse    <= w_long_nxt;
        end
    end

`ifdef KEY_AUTO_REPEAT_EN
    always_ff @(posedge sysclk or negedge resetb) begin
        if (!resetb) begin
            r_rpt_cnt <= c_zero;
        end else begin
            r_rpt_cnt <= w_rpt_nxt;
        end
    end
`endif

endmodule
`default_nettype wire
